// File: rtl/branch_pc_controller_pkg.sv
// Shared branching parameters: default widths, thread-ID width derivation and reset PC.
package branch_pc_controller_pkg;

  localparam int PC_WIDTH_DEFAULT     = 10;
  localparam int THREAD_COUNT_DEFAULT = 8;
  localparam int START_PC_DEFAULT     = 0;

  // A thread ID is at least one bit wide, even for a single-thread build.
  function automatic int thread_width_for(input int count);
    if (count <= 1) begin
      return 1;
    end else begin
      return $clog2(count);
    end
  endfunction

  localparam int THREAD_WIDTH_DEFAULT = thread_width_for(THREAD_COUNT_DEFAULT);

endpackage

// File: rtl/branch_pc_controller_thread_counter.sv
// Modulo-COUNT round-robin thread counter with synchronous reset.
module thread_round_robin_counter
  import branch_pc_controller_pkg::*;
#(
  parameter int COUNT = THREAD_COUNT_DEFAULT,
  parameter int WIDTH = thread_width_for(COUNT)
) (
  input  logic             clock,
  input  logic             reset,
  output logic [WIDTH-1:0] thread_id
);

  localparam logic [WIDTH-1:0] LAST_C = WIDTH'(COUNT - 1);
  localparam logic [WIDTH-1:0] ONE_C  = WIDTH'(1);

  logic [WIDTH-1:0] thread_id_r;

  // Advance one thread per cycle, wrapping after the last thread.
  always_ff @(posedge clock) begin
    if (reset) begin
      thread_id_r <= {WIDTH{1'b0}};
    end else if (thread_id_r == LAST_C) begin
      thread_id_r <= {WIDTH{1'b0}};
    end else begin
      thread_id_r <= thread_id_r + ONE_C;
    end
  end

  assign thread_id = thread_id_r;

endmodule

// File: rtl/branch_pc_controller.sv
// Per-thread PC controller: registers arbiter decisions, computes and stores
// each thread's next PC and presents the fetch PC to instruction fetch.
module branch_pc_controller
  import branch_pc_controller_pkg::*;
#(
  parameter int PC_WIDTH     = PC_WIDTH_DEFAULT,
  parameter int THREAD_COUNT = THREAD_COUNT_DEFAULT,
  parameter int THREAD_WIDTH = thread_width_for(THREAD_COUNT),
  parameter int START_PC     = START_PC_DEFAULT
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    cancel,
  input  logic                    jump,
  input  logic [PC_WIDTH-1:0]     jump_destination,
  output logic [PC_WIDTH-1:0]     pc,
  output logic [THREAD_WIDTH-1:0] pc_thread,
  output logic                    pc_valid,
  output logic                    instruction_cancel
);

  localparam logic [PC_WIDTH-1:0] START_PC_C = PC_WIDTH'(START_PC);
  localparam logic [PC_WIDTH-1:0] PC_ONE_C   = PC_WIDTH'(1);
  // Only a single-thread pipeline ever reads the entry being written.
  localparam logic                BYPASS_EN  = (THREAD_COUNT == 1) ? 1'b1 : 1'b0;

  logic [THREAD_WIDTH-1:0] thread_id_s;
  logic [PC_WIDTH-1:0]     pc_store_r [THREAD_COUNT];

  logic                    valid_r;
  logic                    jump_r;
  logic                    cancel_r;
  logic [PC_WIDTH-1:0]     dest_r;
  logic [THREAD_WIDTH-1:0] thread_r;
  logic [PC_WIDTH-1:0]     base_r;

  logic                    bypass_s;
  logic [PC_WIDTH-1:0]     read_pc_s;
  logic [PC_WIDTH-1:0]     next_pc_s;

  logic [PC_WIDTH-1:0]     pc_r;
  logic [THREAD_WIDTH-1:0] pc_thread_r;
  logic                    pc_valid_r;
  logic                    instruction_cancel_r;

  thread_round_robin_counter #(
    .COUNT (THREAD_COUNT),
    .WIDTH (THREAD_WIDTH)
  ) u_thread_counter (
    .clock     (clock),
    .reset     (reset),
    .thread_id (thread_id_s)
  );

  // Next PC for the thread in stage B: branch target or sequential increment.
  always_comb begin
    next_pc_s = base_r;
    if (jump_r) begin
      next_pc_s = dest_r;
    end else begin
      next_pc_s = base_r + PC_ONE_C;
    end
  end

  // Forward the stage-B result when stage A reads the entry being written.
  always_comb begin
    bypass_s  = BYPASS_EN && valid_r && (thread_r == thread_id_s);
    read_pc_s = START_PC_C;
    if (bypass_s) begin
      read_pc_s = next_pc_s;
    end else begin
      read_pc_s = pc_store_r[thread_id_s];
    end
  end

  // Stage A: capture arbiter decisions and the current thread's base PC.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_r  <= 1'b0;
      jump_r   <= 1'b0;
      cancel_r <= 1'b0;
      dest_r   <= {PC_WIDTH{1'b0}};
      thread_r <= {THREAD_WIDTH{1'b0}};
      base_r   <= START_PC_C;
    end else begin
      valid_r  <= 1'b1;
      jump_r   <= jump;
      cancel_r <= cancel;
      // Gate the target so an undriven destination never enters the pipeline.
      dest_r   <= jump ? jump_destination : {PC_WIDTH{1'b0}};
      thread_r <= thread_id_s;
      base_r   <= read_pc_s;
    end
  end

  // PC store: reset all threads to the start PC, otherwise write back stage B.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < THREAD_COUNT; i++) begin
        pc_store_r[i] <= START_PC_C;
      end
    end else if (valid_r) begin
      pc_store_r[thread_r] <= next_pc_s;
    end
  end

  // Stage B output registers toward instruction fetch.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r                 <= START_PC_C;
      pc_thread_r          <= {THREAD_WIDTH{1'b0}};
      pc_valid_r           <= 1'b0;
      instruction_cancel_r <= 1'b0;
    end else if (valid_r) begin
      pc_r                 <= next_pc_s;
      pc_thread_r          <= thread_r;
      pc_valid_r           <= 1'b1;
      instruction_cancel_r <= cancel_r;
    end else begin
      pc_valid_r           <= 1'b0;
      instruction_cancel_r <= 1'b0;
    end
  end

  assign pc                 = pc_r;
  assign pc_thread          = pc_thread_r;
  assign pc_valid           = pc_valid_r;
  assign instruction_cancel = instruction_cancel_r;

endmodule

// File: tb/tb_branch_pc_controller.sv
// Directed bench for branch_pc_controller: an 8-thread instance and a
// single-thread instance sharing one clock.
module tb_branch_pc_controller;

  logic       clock;
  int         tests;
  int         fails;

  // 8-thread instance
  logic       reset;
  logic       cancel;
  logic       jump;
  logic [9:0] jump_destination;
  logic [9:0] pc;
  logic [2:0] pc_thread;
  logic       pc_valid;
  logic       instruction_cancel;

  // single-thread instance
  logic       reset1;
  logic       cancel1;
  logic       jump1;
  logic [9:0] jump_destination1;
  logic [9:0] pc1;
  logic [0:0] pc_thread1;
  logic       pc_valid1;
  logic       instruction_cancel1;

  localparam logic [9:0] XD = 10'bxxxxxxxxxx;

  branch_pc_controller #(
    .PC_WIDTH     (10),
    .THREAD_COUNT (8),
    .THREAD_WIDTH (3),
    .START_PC     (0)
  ) dut8 (
    .clock              (clock),
    .reset              (reset),
    .cancel             (cancel),
    .jump               (jump),
    .jump_destination   (jump_destination),
    .pc                 (pc),
    .pc_thread          (pc_thread),
    .pc_valid           (pc_valid),
    .instruction_cancel (instruction_cancel)
  );

  branch_pc_controller #(
    .PC_WIDTH     (10),
    .THREAD_COUNT (1),
    .THREAD_WIDTH (1),
    .START_PC     (0)
  ) dut1 (
    .clock              (clock),
    .reset              (reset1),
    .cancel             (cancel1),
    .jump               (jump1),
    .jump_destination   (jump_destination1),
    .pc                 (pc1),
    .pc_thread          (pc_thread1),
    .pc_valid           (pc_valid1),
    .instruction_cancel (instruction_cancel1)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    tests++;
    assert (observed === expected) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  // Drive the 8-thread inputs for the coming edge, then check the outputs
  // produced by the thread captured on the previous edge.
  task automatic step8(input logic rst, input logic j, input logic cn, input logic [9:0] d,
                       input logic ev, input int et, input int ep, input logic ec, input string tag);
    reset = rst; jump = j; cancel = cn; jump_destination = d;
    @(posedge clock); #1;
    check({tag, ".valid"},  {31'd0, pc_valid},           {31'd0, ev});
    check({tag, ".thread"}, {29'd0, pc_thread},          et);
    check({tag, ".pc"},     {22'd0, pc},                 ep);
    check({tag, ".cancel"}, {31'd0, instruction_cancel}, {31'd0, ec});
  endtask

  task automatic step1(input logic rst, input logic j, input logic [9:0] d,
                       input logic ev, input int ep, input string tag);
    reset1 = rst; jump1 = j; cancel1 = 1'b0; jump_destination1 = d;
    @(posedge clock); #1;
    check({tag, ".valid"},  {31'd0, pc_valid1},   {31'd0, ev});
    check({tag, ".thread"}, {31'd0, pc_thread1},  32'd0);
    check({tag, ".pc"},     {22'd0, pc1},         ep);
  endtask

  initial begin
    tests = 0;
    fails = 0;
    reset = 1'b1; jump = 1'b0; cancel = 1'b0; jump_destination = 10'd0;
    reset1 = 1'b1; jump1 = 1'b0; cancel1 = 1'b0; jump_destination1 = 10'd0;
    repeat (3) @(posedge clock);
    #1;
    check("reset.valid",  {31'd0, pc_valid},           32'd0);
    check("reset.pc",     {22'd0, pc},                 32'd0);
    check("reset.thread", {29'd0, pc_thread},          32'd0);
    check("reset.cancel", {31'd0, instruction_cancel}, 32'd0);

    // Release reset: first edge fills stage A, output valid one edge later.
    step8(1'b0, 1'b0, 1'b0, XD, 1'b0, 0, 0, 1'b0, "rel0");
    for (int k = 1; k <= 18; k++) begin
      step8(1'b0, 1'b0, 1'b0, XD, 1'b1, (k - 1) % 8, (k - 1) / 8 + 1, 1'b0, $sformatf("idle%0d", k));
    end

    // Jump on thread 3 to 0x155.
    step8(1'b0, 1'b1, 1'b0, 10'h155, 1'b1, 2, 3,      1'b0, "e19");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 3, 'h155,  1'b0, "jmp_t3");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 4, 3,      1'b0, "e21");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 5, 3,      1'b0, "e22");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 6, 3,      1'b0, "e23");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 7, 3,      1'b0, "e24");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 0, 4,      1'b0, "e25");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 1, 4,      1'b0, "e26");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 2, 4,      1'b0, "e27");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 3, 'h156,  1'b0, "jmp_t3_next");

    // Thread 5 to 0x010, thread 6 to 0x3FF.
    step8(1'b0, 1'b1, 1'b0, 10'h010, 1'b1, 4, 4,      1'b0, "e29");
    step8(1'b0, 1'b1, 1'b0, 10'h3FF, 1'b1, 5, 'h010,  1'b0, "t5_at_010");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 6, 'h3FF,  1'b0, "t6_at_3ff");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 7, 4,      1'b0, "e32");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 0, 5,      1'b0, "e33");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 1, 5,      1'b0, "e34");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 2, 5,      1'b0, "e35");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 3, 'h157,  1'b0, "e36");

    // Cancel without jump on thread 5; wrap on thread 6.
    step8(1'b0, 1'b0, 1'b1, XD,      1'b1, 4, 5,      1'b0, "e37");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 5, 'h011,  1'b1, "cancel_t5");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 6, 'h000,  1'b0, "wrap_t6");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 7, 5,      1'b0, "e40");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 0, 6,      1'b0, "e41");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 1, 6,      1'b0, "e42");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 2, 6,      1'b0, "e43");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 3, 'h158,  1'b0, "e44");

    // Jump and cancel together on thread 5.
    step8(1'b0, 1'b1, 1'b1, 10'h020, 1'b1, 4, 6,      1'b0, "e45");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 5, 'h020,  1'b1, "jmp_cancel_t5");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b1, 6, 'h001,  1'b0, "e47");

    // Reset mid-stream with a pending jump to 0x2AA on thread 0.
    step8(1'b0, 1'b1, 1'b0, 10'h2AA, 1'b1, 7, 6,      1'b0, "pre_rst");
    step8(1'b1, 1'b1, 1'b0, 10'h2AA, 1'b0, 0, 0,      1'b0, "mid_rst0");
    step8(1'b1, 1'b0, 1'b0, 10'h2AA, 1'b0, 0, 0,      1'b0, "mid_rst1");
    step8(1'b0, 1'b0, 1'b0, XD,      1'b0, 0, 0,      1'b0, "mid_rel");
    for (int k = 0; k < 8; k++) begin
      step8(1'b0, 1'b0, 1'b0, XD, 1'b1, k, 1, 1'b0, $sformatf("restart%0d", k));
    end

    // Single-thread build: back-to-back jumps then increments need forwarding.
    reset = 1'b1;
    step1(1'b0, 1'b1, 10'h100, 1'b0, 0,      "st_rel");
    step1(1'b0, 1'b1, 10'h200, 1'b1, 'h100,  "st_j100");
    step1(1'b0, 1'b0, XD,      1'b1, 'h200,  "st_j200");
    step1(1'b0, 1'b0, XD,      1'b1, 'h201,  "st_fwd1");
    step1(1'b0, 1'b0, XD,      1'b1, 'h202,  "st_fwd2");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
